// File: rtl/demapper_cfg_pkg.sv
// demapper_cfg_pkg: shared types and constants for the demapper configuration
// sequencer (FSM states, constellation modes, AXI response code, register map).
package demapper_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_64QAM = 2'd3
    } mode_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Demapper register map: register i lives at REG_BASE + REG_STRIDE * i.
    localparam int REG_BASE   = 0;
    localparam int REG_STRIDE = 4;

    // Tag in the top byte of every table word, lets software spot stale data.
    localparam logic [7:0] ROM_TAG = 8'hDA;

    // Per-register soft-decision scale step for each constellation.
    function automatic logic [15:0] mode_scale(input logic [1:0] mode);
        logic [15:0] scale;
        case (mode)
            MODE_BPSK:  scale = 16'd16;
            MODE_QPSK:  scale = 16'd11;
            MODE_16QAM: scale = 16'd5;
            default:    scale = 16'd2;
        endcase
        return scale;
    endfunction

endpackage

// File: rtl/demapper_cfg_rom.sv
// demapper_cfg_rom: combinational table of demapper register values.
// Word layout: {ROM_TAG[7:0], 2'b00, mode[1:0], index[3:0], scale*(index+1)[15:0]}.
module demapper_cfg_rom
    import demapper_cfg_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [3:0]  index,
    output logic [31:0] data
);

    logic [15:0] scale;
    logic [15:0] level;

    // Build the register word from the constellation scale and register index.
    always_comb begin
        scale = mode_scale(mode);
        level = scale * ({12'd0, index} + 16'd1);
        data  = {ROM_TAG, 2'b00, mode, index, level};
    end

endmodule

// File: rtl/demapper_cfg_seq.sv
// demapper_cfg_seq: AXI4-Lite master that writes C_NUM_REGS demapper registers
// from demapper_cfg_rom for the selected MODE, one transaction at a time.
// Optional feature macro: DEMAPPER_CFG_READBACK_EN reads every register back
// after the writes and flags ERROR on a data or response mismatch.
//
// Handshake rule on every AXI channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high; this master never drops a VALID before
// that edge and keeps the address/data stable while its VALID is high.
module demapper_cfg_seq
    import demapper_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          INIT_AXI_TXN,
    input  logic [1:0]                    MODE,
    output logic                          TXN_DONE,
    output logic                          ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam logic [4:0] LAST_INDEX = 5'(C_NUM_REGS - 1);

    state_t                        state, state_next;
    logic                          init_q;
    logic                          start;
    logic [1:0]                    mode_q;
    logic [4:0]                    index;
    logic                          index_last;
    logic [31:0]                   rom_data;
    logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr;
    logic                          aw_valid, w_valid, aw_done, w_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_data;
    logic                          txn_done, error;
    logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                          aw_complete, w_complete;

    assign start       = INIT_AXI_TXN && !init_q;
    assign index_last  = (index == LAST_INDEX);
    assign reg_addr    = C_M_AXI_ADDR_WIDTH'(REG_BASE + REG_STRIDE * int'(index));
    assign aw_hs       = aw_valid && M_AXI_AWREADY;
    assign w_hs        = w_valid && M_AXI_WREADY;
    assign b_hs        = (state == WR_RESP) && M_AXI_BVALID;
    assign aw_complete = aw_done || aw_hs;
    assign w_complete  = w_done || w_hs;

    demapper_cfg_rom u_rom (
        .mode  (mode_q),
        .index (index[3:0]),
        .data  (rom_data)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: one outstanding transaction, walk the register index.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = WR;
            WR:         if (aw_complete && w_complete) state_next = WR_RESP;
            WR_RESP: begin
                if (b_hs) begin
                    if (!index_last) state_next = WR;
`ifdef DEMAPPER_CFG_READBACK_EN
                    else             state_next = RD_ADDR;
`else
                    else             state_next = DONE;
`endif
                end
            end
            RD_ADDR:    if (ar_hs) state_next = RD_DATA;
            RD_DATA:    if (r_hs)  state_next = index_last ? DONE : RD_ADDR;
            default:    state_next = IDLE;
        endcase
    end

    // Start capture, write-channel valids, register index and status flags.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            // A request level held through reset must not start a sequence.
            init_q   <= 1'b1;
            mode_q   <= '0;
            index    <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            txn_done <= 1'b0;
            error    <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            if (start && (state == IDLE || state == DONE)) begin
                mode_q   <= MODE;
                index    <= '0;
                txn_done <= 1'b0;
                error    <= 1'b0;
            end
            // AW and W rise together one cycle into WR and retire independently.
            if (state == WR) begin
                if (aw_hs) begin
                    aw_valid <= 1'b0;
                    aw_done  <= 1'b1;
                end else if (!aw_valid && !aw_done) begin
                    aw_valid <= 1'b1;
                    aw_addr  <= reg_addr;
                end
                if (w_hs) begin
                    w_valid <= 1'b0;
                    w_done  <= 1'b1;
                end else if (!w_valid && !w_done) begin
                    w_valid <= 1'b1;
                    w_data  <= C_M_AXI_DATA_WIDTH'(rom_data);
                end
                if (aw_complete && w_complete) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            end
            // A bad response is recorded but the sequence carries on.
            if (b_hs) begin
                if (M_AXI_BRESP != RESP_OKAY) error <= 1'b1;
                index <= index_last ? 5'd0 : index + 5'd1;
            end
            if (r_hs) begin
                if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != C_M_AXI_DATA_WIDTH'(rom_data))
                    error <= 1'b1;
                index <= index_last ? 5'd0 : index + 5'd1;
            end
            if (state != DONE && state_next == DONE) txn_done <= 1'b1;
        end
    end

`ifdef DEMAPPER_CFG_READBACK_EN
    logic                          ar_valid;
    logic [C_M_AXI_ADDR_WIDTH-1:0] ar_addr;

    assign ar_hs = ar_valid && M_AXI_ARREADY;
    assign r_hs  = (state == RD_DATA) && M_AXI_RVALID;

    // Read-address valid rises one cycle into RD_ADDR and holds until accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_valid <= 1'b0;
            ar_addr  <= '0;
        end else if (state == RD_ADDR) begin
            if (ar_hs) begin
                ar_valid <= 1'b0;
            end else if (!ar_valid) begin
                ar_valid <= 1'b1;
                ar_addr  <= reg_addr;
            end
        end
    end

    assign M_AXI_ARVALID = ar_valid;
    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_RREADY  = (state == RD_DATA);
`else
    logic rd_unused;

    assign rd_unused     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign ar_hs         = 1'b0;
    assign r_hs          = 1'b0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_RREADY  = 1'b0;
`endif

    assign M_AXI_AWADDR  = aw_addr;
    assign M_AXI_AWVALID = aw_valid;
    assign M_AXI_WDATA   = w_data;
    assign M_AXI_WVALID  = w_valid;
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign TXN_DONE      = txn_done;
    assign ERROR         = error;

endmodule

// File: tb/tb_demapper_cfg_seq.sv
// tb_demapper_cfg_seq: AXI4-Lite slave model plus scoreboard for demapper_cfg_seq.
// Works for both builds; DEMAPPER_CFG_READBACK_EN selects the readback expectations.
module tb_demapper_cfg_seq;

    localparam int NREGS = 8;
`ifdef DEMAPPER_CFG_READBACK_EN
    localparam int EXP_READS = NREGS;
    localparam int RB        = 1;
`else
    localparam int EXP_READS = 0;
    localparam int RB        = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        aclk, aresetn, init_axi_txn;
    logic [1:0]  mode;
    logic        txn_done, error;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    demapper_cfg_seq #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_NUM_REGS         (NREGS)
    ) dut (
        .ACLK          (aclk),
        .ARESETN       (aresetn),
        .INIT_AXI_TXN  (init_axi_txn),
        .MODE          (mode),
        .TXN_DONE      (txn_done),
        .ERROR         (error),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_q[$];

    int cfg_aw_delay = 0, cfg_berr = -1, cfg_rcorrupt = -1, cur_mode = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_pend, r_pend, aw_wait, cyc;
    int awvalid_seen, wvalid_seen, arvalid_seen;
    int aw_cyc[16];
    bit aw_hold, w_hold, ar_hold;
    logic [31:0] aw_hold_addr, w_hold_data, ar_hold_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected table word. For 16QAM the words are 0xDA20_0005, 0xDA21_000A,
    // 0xDA22_000F, ... 0xDA27_0028 (scale step 5 per register).
    function automatic logic [31:0] rom_model(input int m, input int idx);
        int          scale;
        logic [1:0]  mb;
        logic [3:0]  ib;
        logic [15:0] lvl;
        case (m)
            0:       scale = 16;
            1:       scale = 11;
            2:       scale = 5;
            default: scale = 2;
        endcase
        mb  = m[1:0];
        ib  = idx[3:0];
        lvl = 16'(scale * (idx + 1));
        return {8'hDA, 2'b00, mb, ib, lvl};
    endfunction

    task automatic reset_counters();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awvalid_seen = 0; wvalid_seen = 0; arvalid_seen = 0;
        for (int i = 0; i < 16; i++) aw_cyc[i] = 0;
    endtask

    // ---------------- slave driver / monitor (acts on falling edges) ----------------
    initial begin
        bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        cyc = 0; b_pend = 0; r_pend = 0; aw_wait = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                b_pend = 0; r_pend = 0; aw_wait = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0;
            end else begin
                if (awvalid) awvalid_seen++;
                if (wvalid)  wvalid_seen++;
                if (arvalid) arvalid_seen++;
                // A valid that was not accepted must still be up with the same payload.
                if (aw_hold) begin
                    check("awvalid_held", awvalid, 1);
                    check("awaddr_stable", awaddr, aw_hold_addr);
                end
                if (w_hold) begin
                    check("wvalid_held", wvalid, 1);
                    check("wdata_stable", wdata, w_hold_data);
                end
                if (ar_hold) begin
                    check("arvalid_held", arvalid, 1);
                    check("araddr_stable", araddr, ar_hold_addr);
                end
                // Drive slave side for the coming rising edge.
                awready = (cfg_aw_delay == 0) ? 1'b1 : (awvalid && aw_wait >= cfg_aw_delay);
                wready  = 1'b1;
                arready = 1'b1;
                bvalid  = (b_pend > 0);
                bresp   = (b_cnt == cfg_berr) ? 2'b10 : 2'b00;
                rvalid  = (r_pend > 0);
                rdata   = rom_model(cur_mode, r_cnt) ^ ((r_cnt == cfg_rcorrupt) ? 32'h0000_0100 : 32'h0);
                rresp   = 2'b00;
                aw_fire = awvalid && awready;
                w_fire  = wvalid && wready;
                b_fire  = bvalid && bready;
                ar_fire = arvalid && arready;
                r_fire  = rvalid && rready;
                if (awvalid && !awready) aw_wait++;
                if (aw_fire) begin
                    aw_wait = 0;
                    if (aw_cnt < 16) aw_cyc[aw_cnt] = cyc;
                    if (exp_addr_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL aw_extra: unexpected write to %h", awaddr);
                    end else begin
                        check("awaddr", awaddr, exp_addr_q.pop_front());
                    end
                    aw_cnt++;
                end
                if (w_fire) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL w_extra: unexpected write data %h", wdata);
                    end else begin
                        check("wdata", wdata, exp_q.pop_front());
                    end
                    w_cnt++;
                end
                if (b_fire) b_cnt++;
                if (ar_fire) begin
                    check("araddr", araddr, 32'(4 * ar_cnt));
                    ar_cnt++;
                end
                if (r_fire) r_cnt++;
                b_pend       = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_cnt;
                r_pend       = ar_cnt - r_cnt;
                aw_hold      = awvalid && !aw_fire;
                w_hold       = wvalid && !w_fire;
                ar_hold      = arvalid && !ar_fire;
                aw_hold_addr = awaddr;
                w_hold_data  = wdata;
                ar_hold_addr = araddr;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expected(input int m);
        for (int i = 0; i < NREGS; i++) begin
            exp_addr_q.push_back(32'(4 * i));
            exp_q.push_back(rom_model(m, i));
        end
    endtask

    task automatic pulse_init(input int m);
        @(negedge aclk);
        mode         = m[1:0];
        init_axi_txn = 1'b1;
        @(negedge aclk);
        init_axi_txn = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (txn_done !== 1'b1 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check("done_within_budget", txn_done, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_txn_done"}, txn_done, 0);
        check({tag, "_error"},    error,    0);
        check({tag, "_awvalid"},  awvalid,  0);
        check({tag, "_wvalid"},   wvalid,   0);
        check({tag, "_bready"},   bready,   0);
        check({tag, "_arvalid"},  arvalid,  0);
        check({tag, "_rready"},   rready,   0);
        check({tag, "_awaddr"},   awaddr,   0);
        check({tag, "_wdata"},    wdata,    0);
        check({tag, "_araddr"},   araddr,   0);
    endtask

    typedef struct {
        int mode;
        int aw_delay;
        int berr;
        int rcorrupt;
        int exp_err;
    } vec_t;

    task automatic run_seq(input vec_t v, input string tag);
        cfg_aw_delay = v.aw_delay;
        cfg_berr     = v.berr;
        cfg_rcorrupt = v.rcorrupt;
        cur_mode     = v.mode;
        reset_counters();
        push_expected(v.mode);
        pulse_init(v.mode);
        check({tag, "_start_clears_done"},  txn_done, 0);
        check({tag, "_start_clears_error"}, error,    0);
        wait_done(800);
        check({tag, "_error"},        error, 32'(v.exp_err));
        check({tag, "_aw_count"},     aw_cnt, NREGS);
        check({tag, "_w_count"},      w_cnt,  NREGS);
        check({tag, "_b_count"},      b_cnt,  NREGS);
        check({tag, "_ar_count"},     ar_cnt, EXP_READS);
        check({tag, "_sb_empty"},     exp_addr_q.size() + exp_q.size(), 0);
        if (v.aw_delay == 0)
            for (int i = 1; i < NREGS; i++)
                check($sformatf("%s_wr_gap_%0d", tag, i), aw_cyc[i] - aw_cyc[i-1], 3);
        repeat (3) @(negedge aclk);
        check({tag, "_done_held"},  txn_done, 1);
        check({tag, "_error_held"}, error, 32'(v.exp_err));
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[5];

    initial begin
        int n;
        vec_t v;
        //          mode aw_delay berr rcorrupt exp_err
        vecs[0] = '{2,   0,       -1,  -1,      0};
        vecs[1] = '{2,   0,        3,  -1,      1};
        vecs[2] = '{0,   3,       -1,  -1,      0};
        vecs[3] = '{1,   0,       -1,   5,      RB};
        vecs[4] = '{3,   1,        7,  -1,      1};

        aresetn      = 1'b0;
        init_axi_txn = 1'b0;
        mode         = 2'd0;
        reset_counters();
        repeat (3) @(negedge aclk);
        check_outputs_zero("reset");
        aresetn = 1'b1;
        repeat (6) @(negedge aclk);
        check("idle_no_aw", awvalid_seen, 0);
        check("idle_no_w",  wvalid_seen,  0);

        for (int i = 0; i < 5; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

        // A second start edge while writing is ignored; MODE change is not picked up.
        cfg_aw_delay = 0; cfg_berr = -1; cfg_rcorrupt = -1; cur_mode = 1;
        reset_counters();
        push_expected(1);
        pulse_init(1);
        n = 0;
        while (awvalid !== 1'b1 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("busy_wr_reached", awvalid, 1);
        mode         = 2'd3;
        init_axi_txn = 1'b1;
        @(negedge aclk);
        init_axi_txn = 1'b0;
        wait_done(800);
        check("busy_error",    error,  0);
        check("busy_aw_count", aw_cnt, NREGS);
        check("busy_sb_empty", exp_addr_q.size() + exp_q.size(), 0);

        // Reset while waiting for a write response.
        cur_mode = 0;
        reset_counters();
        push_expected(0);
        pulse_init(0);
        n = 0;
        while (bready !== 1'b1 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("wr_resp_reached", bready, 1);
        aresetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge aclk);
        check("midreset_next_bready",  bready,  0);
        check("midreset_next_awvalid", awvalid, 0);
        exp_addr_q.delete();
        exp_q.delete();
        reset_counters();
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        check("post_reset_no_aw", awvalid_seen, 0);
        check("post_reset_no_w",  wvalid_seen,  0);
        check("post_reset_idle_done", txn_done, 0);
        v = '{2, 0, -1, -1, 0};
        run_seq(v, "after_reset");

        check("no_ar_without_readback", arvalid_seen > 0, RB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached with %0d errors", n_errors);
        $fatal(1, "time limit");
    end

endmodule
